ifq_line_fetch_queue: RTL and testbench
=======================================

// Module: ifq_line_fetch_queue
// PURPOSE
//  Parametrised instruction fetch queue. Sits between the I-cache and dispatch.
//  Requests full cache lines and splits each line into words. Queues {pc, inst} pairs
//  for in-order dispatch. Handles branch/jump redirects with queue flush and cache abort.
// PARAMETERS
//  XLEN            32    instruction and PC width
//  WORDS_PER_LINE  4     instructions per cache line; power of 2, >=2
//  DEPTH           16    queue entries; power of 2, >=WORDS_PER_LINE
//  RESET_PC        0     byte address of the first fetch after reset
// PORTS
//  clk                 in   1                  clock
//  rst                 in   1                  synchronous, active-high reset
//  pc_in               out  XLEN               line-aligned byte address of the cache request
//  cache_rd_en         out  1                  cache read request, one-cycle pulse
//  cache_abort         out  1                  cancel the outstanding cache request
//  dout                in   XLEN*WORDS_PER_LINE  returned line; word0 in the LSBs
//  dout_valid          in   1                  dout valid for one cycle
//  pc_out              out  XLEN               PC of the head instruction
//  inst                out  XLEN               head instruction
//  empty               out  1                  no instruction is presented
//  inst_rd_en          in   1                  dispatch pops the head; ignored while empty=1
//  jmp_branch_address  in   XLEN               redirect target, byte address
//  jmp_branch_valid    in   1                  redirect strobe
//  count               out  $clog2(DEPTH)+1    queue occupancy
// BEHAVIOUR
//  - Clock and reset: one clock (clk). rst is synchronous and active-high.
//  - Reset values: cache_rd_en=0, cache_abort=0, empty=1, count=0, pc_out=0, inst=0,
//    pc_in=RESET_PC. Internal state: FSM=S_REQ, fetch_pc=RESET_PC, offset=RESET_PC word index.
//  - Addressing:
//    * PCs are byte addresses.
//    * Consecutive words differ by 4.
//    * Word index = pc[$clog2(WORDS_PER_LINE)+1:2].
//    * pc_in = fetch_pc with the low $clog2(WORDS_PER_LINE)+2 bits zeroed.
//  - FSM (in ifq_pkg as ifq_state_t):
//    * S_REQ: drive cache_rd_en=1 for one cycle, then go to S_WAIT.
//    * S_WAIT: wait for dout_valid. On dout_valid:
//      - capture the line;
//      - push word[offset] (pc = fetch_pc) this cycle, unless it was bypassed;
//      - if offset is the last word, go to S_REQ with fetch_pc = next line;
//      - otherwise go to S_FILL at offset+1.
//      - If the queue cannot accept the push, stay in S_FILL at the same offset instead.
//    * S_FILL: push one buffered word per cycle. After the last word:
//      fetch_pc += line size, offset=0, go to S_REQ.
//  - Push/pop rules:
//    * A push is accepted when count<DEPTH, or when a pop happens in the same cycle.
//    * When full with no pop, the FSM holds in place (stall).
//    * A pop happens when inst_rd_en=1 and the queue is non-empty.
//    * Simultaneous push and pop leaves count unchanged.
//    * Pointers wrap modulo DEPTH.
//  - Output timing: a word pushed in cycle T is visible at pc_out/inst in T+1, with empty=0.
//    While the queue is empty, inst=0 and pc_out=0 (unless bypassing).
//  - Redirect (jmp_branch_valid=1 in cycle T):
//    * All entries are flushed; count=0 at T+1.
//    * In cycle T, inst_rd_en and dout_valid are ignored and no push happens.
//    * cache_abort=1 combinationally in T when FSM=S_WAIT; otherwise 0.
//    * At T+1: FSM=S_REQ, fetch_pc=jmp_branch_address, offset=target word index.
//      The word at the target offset is the first one queued.
//  - Priority: rst > jmp_branch_valid > normal operation.
//  - Reset mid-operation: an outstanding request is dropped silently. dout_valid in the
//    reset cycle is ignored.
// CONFIGURATION
//  - Macro: IFQ_BYPASS_EN.
//  - Defined: in S_WAIT with the queue empty and dout_valid=1, the word is bypassed:
//    * word[offset] and its pc drive inst/pc_out combinationally, with empty=0, same cycle.
//    * If inst_rd_en=1 that cycle, the word is consumed and not pushed; fill starts at offset+1.
//  - Undefined: no combinational dout->inst path. The first word appears one cycle after
//    dout_valid.
// STRUCTURE
//  - ifq_pkg contains:
//    * ifq_state_t {S_REQ, S_WAIT, S_FILL};
//    * ifq_entry_t struct {pc, inst};
//    * function word_idx(pc);
//    * localparams LINE_W and OFF_W.
//  - Sub-module ifq_ring_buffer #(DEPTH, ifq_entry_t):
//    * registered storage;
//    * rp/wp pointers;
//    * push, pop and flush;
//    * count, full and empty.
//  - The top level holds the FSM, line buffer, fetch_pc and bypass mux.
// TESTING
//  1. Reset, then a line returns with words A0..A3:
//     - cache_rd_en pulses with pc_in=0x0;
//     - dout_valid returns 0x10,0x11,0x12,0x13;
//     - queue pops in order with pc_out 0x0, 0x4, 0x8, 0xC;
//     - a second request follows with pc_in=0x10.
//  2. Redirect mid-line:
//     - jmp_branch_valid with address 0x108 during S_FILL;
//     - count=0 next cycle; next pc_in=0x100;
//     - first pc_out=0x108, then 0x10C;
//     - no further words from the old line appear.
//  3. Abort: redirect while in S_WAIT gives cache_abort=1 in the same cycle and a new
//     request the next cycle.
//  4. Full stall:
//     - hold inst_rd_en=0 for DEPTH=16 pushes;
//     - count saturates at 16 and the FSM holds in S_FILL;
//     - one pop lets exactly one push through; pop and push in the same cycle keep count=16.
//  5. Bypass:
//     - with IFQ_BYPASS_EN, empty queue and inst_rd_en=1: inst=word[offset] in the
//       dout_valid cycle, and count stays at 0 after consuming it;
//     - without the macro: empty=1 in that cycle and the word appears in the next cycle.
//  6. Reset in S_WAIT: stale dout_valid ignored; next request uses pc_in=RESET_PC.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types for the instruction line-fetch queue.
// Entry layout, fetch FSM states and word-index helper.
package ifq_pkg;

  localparam int XLEN_DEF = 32;
  localparam int WPL_DEF  = 4;
  localparam int OFF_W    = $clog2(WPL_DEF);
  localparam int LINE_W   = XLEN_DEF * WPL_DEF;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FILL
  } ifq_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
  } ifq_entry_t;

  function automatic logic [OFF_W-1:0] word_idx(
    input logic [XLEN_DEF-1:0] pc
  );
    return pc[OFF_W+1:2];
  endfunction

endpackage

// File: rtl/ifq_ring_buffer.sv
// Registered ring buffer with push/pop/flush and occupancy.
// Caller only asserts push when the entry can be accepted.
module ifq_ring_buffer #(
  parameter int  DEPTH = 16,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       din,
  output T                       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_rp;
  logic [AW-1:0]  r_wp;
  logic [AW:0]    r_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wp <= r_wp + 1'b1;
      if (pop)  r_rp <= r_rp + 1'b1;
      unique case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush)
      r_mem[r_wp] <= din;
  end

  assign dout  = r_mem[r_rp];
  assign count = r_cnt;
  assign full  = (r_cnt == (AW+1)'(DEPTH));
  assign empty = (r_cnt == '0);

endmodule

// File: rtl/ifq_line_fetch_queue.sv
// Line-fetch instruction queue between I-cache and dispatch.
// Optional same-cycle dout->inst bypass under `IFQ_BYPASS_EN.
module ifq_line_fetch_queue
  import ifq_pkg::*;
#(
  parameter int              XLEN           = XLEN_DEF,
  parameter int              WORDS_PER_LINE = WPL_DEF,
  parameter int              DEPTH          = 16,
  parameter logic [XLEN-1:0] RESET_PC       = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [XLEN-1:0]                pc_in,
  output logic                           cache_rd_en,
  output logic                           cache_abort,
  input  logic [XLEN*WORDS_PER_LINE-1:0] dout,
  input  logic                           dout_valid,
  output logic [XLEN-1:0]                pc_out,
  output logic [XLEN-1:0]                inst,
  output logic                           empty,
  input  logic                           inst_rd_en,
  input  logic [XLEN-1:0]                jmp_branch_address,
  input  logic                           jmp_branch_valid,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int              OW    = $clog2(WORDS_PER_LINE);
  localparam logic [XLEN-1:0] LBYTE = XLEN'(WORDS_PER_LINE * 4);
  localparam logic [OW-1:0]   LAST  = OW'(WORDS_PER_LINE - 1);

  ifq_state_t                    r_state;
  logic [XLEN-1:0]               r_fetch_pc;
  logic [OW-1:0]                 r_off;
  logic [XLEN*WORDS_PER_LINE-1:0] r_line;

  logic [XLEN-1:0]               w_base;
  logic [XLEN*WORDS_PER_LINE-1:0] w_src;
  logic [XLEN-1:0]               w_word;
  logic [XLEN-1:0]               w_word_pc;
  logic                          w_redir;
  logic                          w_have;
  logic                          w_byp;
  logic                          w_byp_take;
  logic                          w_pop;
  logic                          w_push;
  logic                          w_adv;
  logic                          w_q_empty;
  logic                          w_q_full;
  ifq_entry_t                    w_din;
  ifq_entry_t                    w_head;

  assign w_base    = {r_fetch_pc[XLEN-1:OW+2], {(OW+2){1'b0}}};
  assign w_src     = (r_state == S_WAIT) ? dout : r_line;
  assign w_word    = w_src[r_off*XLEN +: XLEN];
  assign w_word_pc = w_base | {{(XLEN-OW-2){1'b0}}, r_off, 2'b00};
  assign w_redir   = jmp_branch_valid;

  assign w_have = !w_redir &&
                  (((r_state == S_WAIT) && dout_valid) ||
                   (r_state == S_FILL));

`ifdef IFQ_BYPASS_EN
  assign w_byp = !w_redir && (r_state == S_WAIT) &&
                 dout_valid && w_q_empty;
`else
  assign w_byp = 1'b0;
`endif

  assign w_pop      = inst_rd_en && !w_q_empty && !w_redir;
  assign w_byp_take = w_byp && inst_rd_en;
  assign w_push     = w_have && !w_byp_take && (!w_q_full || w_pop);
  // A consumed bypass word advances the fill exactly like a push.
  assign w_adv      = w_push || w_byp_take;

  assign w_din.pc   = w_word_pc;
  assign w_din.inst = w_word;

  ifq_ring_buffer #(
    .DEPTH (DEPTH),
    .T     (ifq_entry_t)
  ) u_rb (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_redir),
    .din   (w_din),
    .dout  (w_head),
    .count (count),
    .full  (w_q_full),
    .empty (w_q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_off      <= word_idx(RESET_PC);
    end else if (w_redir) begin
      r_state    <= S_REQ;
      r_fetch_pc <= jmp_branch_address;
      r_off      <= word_idx(jmp_branch_address);
    end else begin
      unique case (r_state)
        S_REQ: r_state <= S_WAIT;
        S_WAIT, S_FILL: begin
          if (w_adv) begin
            if (r_off == LAST) begin
              r_fetch_pc <= w_base + LBYTE;
              r_off      <= '0;
              r_state    <= S_REQ;
            end else begin
              r_off      <= r_off + 1'b1;
              r_state    <= S_FILL;
            end
          end else if (w_have) begin
            r_state <= S_FILL;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !w_redir && (r_state == S_WAIT) && dout_valid)
      r_line <= dout;
  end

  assign pc_in       = w_base;
  assign cache_rd_en = !rst && !w_redir && (r_state == S_REQ);
  assign cache_abort = !rst && w_redir && (r_state == S_WAIT);

  assign empty  = w_q_empty && !w_byp;
  assign inst   = w_byp     ? w_word    :
                  w_q_empty ? '0        : w_head.inst;
  assign pc_out = w_byp     ? w_word_pc :
                  w_q_empty ? '0        : w_head.pc;

endmodule

// File: tb/tb_ifq_line_fetch_queue.sv
// Scoreboard bench for ifq_line_fetch_queue (DEPTH=16, 4 words/line).
// Driver queues expected {pc,inst}; monitor checks each pop.
module tb_ifq_line_fetch_queue;

  logic         clk;
  logic         rst;
  logic [31:0]  pc_in;
  logic         cache_rd_en;
  logic         cache_abort;
  logic [127:0] dout;
  logic         dout_valid;
  logic [31:0]  pc_out;
  logic [31:0]  inst;
  logic         empty;
  logic         inst_rd_en;
  logic [31:0]  jmp_branch_address;
  logic         jmp_branch_valid;
  logic [4:0]   count;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];
  logic [63:0] e;

  ifq_line_fetch_queue dut (
    .clk                (clk),
    .rst                (rst),
    .pc_in              (pc_in),
    .cache_rd_en        (cache_rd_en),
    .cache_abort        (cache_abort),
    .dout               (dout),
    .dout_valid         (dout_valid),
    .pc_out             (pc_out),
    .inst               (inst),
    .empty              (empty),
    .inst_rd_en         (inst_rd_en),
    .jmp_branch_address (jmp_branch_address),
    .jmp_branch_valid   (jmp_branch_valid),
    .count              (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && inst_rd_en && !jmp_branch_valid && !empty) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop pc=%0h inst=%0h required=none",
                 pc_out, inst);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", pc_out, e[63:32]);
        chk("pop_inst", inst, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    while (!cache_rd_en && n < 30) begin
      step();
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(cache_rd_en), 1);
    chk("req_pc", pc_in, exp);
  endtask

  task automatic give_line(input logic [31:0] base, input logic [31:0] v,
                           input int first, input bit rec);
    step();
    dout = {v + 32'd3, v + 32'd2, v + 32'd1, v};
    dout_valid = 1'b1;
    if (rec)
      for (int i = first; i < 4; i++)
        sb.push_back({base + 32'(4 * i), v + 32'(i)});
    @(negedge clk);
    step();
    dout_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    dout = '0;
    dout_valid = 1'b0;
    inst_rd_en = 1'b0;
    jmp_branch_address = '0;
    jmp_branch_valid = 1'b0;

    // reset
    step();
    step();
    @(negedge clk);
    chk("rst_rd_en", 32'(cache_rd_en), 0);
    chk("rst_abort", 32'(cache_abort), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc_in", pc_in, 0);
    step();
    rst = 1'b0;

    // first line, then next-line request
    wait_req(32'h0);
    step();
    @(negedge clk);
    chk("req_pulse", 32'(cache_rd_en), 0);
    give_line(32'h0, 32'h10, 0, 1);
    wait_req(32'h10);
    chk("line_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      step();
      inst_rd_en = 1'b1;
      @(negedge clk);
    end
    step();
    inst_rd_en = 1'b0;
    @(negedge clk);
    chk("drain_count", 32'(count), 0);
    chk("drain_empty", 32'(empty), 1);

    // redirect during fill
    give_line(32'h10, 32'h20, 0, 0);
    @(negedge clk);
    step();
    jmp_branch_valid = 1'b1;
    jmp_branch_address = 32'h108;
    @(negedge clk);
    chk("fill_abort", 32'(cache_abort), 0);
    step();
    jmp_branch_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 0);
    chk("redir_rd_en", 32'(cache_rd_en), 1);
    chk("redir_pc_in", pc_in, 32'h100);
    step();
    @(negedge clk);
    give_line(32'h100, 32'h30, 2, 1);
    wait_req(32'h110);
    chk("redir_count", 32'(count), 2);
    for (int i = 0; i < 2; i++) begin
      step();
      inst_rd_en = 1'b1;
      @(negedge clk);
    end
    step();
    inst_rd_en = 1'b0;
    @(negedge clk);
    chk("redir_drain", 32'(count), 0);

    // abort in S_WAIT
    step();
    jmp_branch_valid = 1'b1;
    jmp_branch_address = 32'h200;
    @(negedge clk);
    chk("wait_abort", 32'(cache_abort), 1);
    step();
    jmp_branch_valid = 1'b0;
    @(negedge clk);
    chk("abort_clear", 32'(cache_abort), 0);
    chk("abort_rd_en", 32'(cache_rd_en), 1);
    chk("abort_pc_in", pc_in, 32'h200);

    // full stall
    give_line(32'h200, 32'h40, 0, 1);
    wait_req(32'h210);
    give_line(32'h210, 32'h50, 0, 1);
    wait_req(32'h220);
    give_line(32'h220, 32'h60, 0, 1);
    wait_req(32'h230);
    give_line(32'h230, 32'h70, 0, 1);
    wait_req(32'h240);
    chk("full_count", 32'(count), 16);
    give_line(32'h240, 32'h80, 0, 1);
    @(negedge clk);
    chk("stall_count", 32'(count), 16);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("stall_count", 32'(count), 16);
      chk("stall_no_req", 32'(cache_rd_en), 0);
    end
    step();
    inst_rd_en = 1'b1;
    @(negedge clk);
    step();
    inst_rd_en = 1'b0;
    @(negedge clk);
    chk("pop_push_count", 32'(count), 16);
    chk("head_after_pop", pc_out, 32'h204);
    step();
    @(negedge clk);
    chk("one_push_only", 32'(count), 16);
    step();
    inst_rd_en = 1'b1;
    repeat (24) begin
      @(negedge clk);
      step();
    end
    inst_rd_en = 1'b0;
    @(negedge clk);
    chk("full_drain", 32'(count), 0);

    // bypass / no-bypass on empty queue
    step();
    inst_rd_en = 1'b1;
    dout = {32'h93, 32'h92, 32'h91, 32'h90};
    dout_valid = 1'b1;
    for (int i = 0; i < 4; i++)
      sb.push_back({32'h250 + 32'(4 * i), 32'h90 + 32'(i)});
    @(negedge clk);
`ifdef IFQ_BYPASS_EN
    chk("byp_empty", 32'(empty), 0);
    chk("byp_inst", inst, 32'h90);
    chk("byp_pc", pc_out, 32'h250);
`else
    chk("nobyp_empty", 32'(empty), 1);
    chk("nobyp_inst", inst, 0);
`endif
    step();
    dout_valid = 1'b0;
    @(negedge clk);
`ifdef IFQ_BYPASS_EN
    chk("byp_count", 32'(count), 0);
`else
    chk("late_empty", 32'(empty), 0);
    chk("late_pc", pc_out, 32'h250);
`endif
    repeat (6) begin
      step();
      @(negedge clk);
    end
    step();
    inst_rd_en = 1'b0;
    @(negedge clk);
    chk("byp_drain", 32'(count), 0);
    chk("byp_drain_empty", 32'(empty), 1);

    // reset while waiting, with stale return
    step();
    rst = 1'b1;
    dout = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    dout_valid = 1'b1;
    @(negedge clk);
    chk("rstw_rd_en", 32'(cache_rd_en), 0);
    step();
    rst = 1'b0;
    dout_valid = 1'b0;
    @(negedge clk);
    chk("rstw_count", 32'(count), 0);
    chk("rstw_empty", 32'(empty), 1);
    chk("rstw_rd_en", 32'(cache_rd_en), 1);
    chk("rstw_pc_in", pc_in, 32'h0);
    repeat (3) begin
      step();
      @(negedge clk);
    end
    chk("rstw_still_empty", 32'(count), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
